// File: rtl/lm_sm_sequencer.sv
// Load/store-multiple sequencer: walks a register mask R0..R7, one memory transaction per set bit.
// Latency 2 + 2*N cycles from start to done (zero-wait); each mem_ready=0 cycle in XFER stretches it by one.
module lm_sm_sequencer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int NREG      = 8,
    parameter int ADDR_STEP = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      is_store,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [NREG-1:0]           reg_mask,
    output logic [$clog2(NREG)-1:0]   rf_addr,
    input  logic [DATA_W-1:0]         rf_rdata,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      rf_write_n,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rd,
    output logic                      mem_wr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ready,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREG+1)-1:0] xfer_count
);

    localparam int IDX_W = $clog2(NREG);
    localparam int CNT_W = $clog2(NREG + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_XFER,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [NREG-1:0]   mask_r;
    logic              store_r;
    logic [IDX_W-1:0]  low_idx;

    // Lowest set bit of the remaining mask; iterating downward leaves the smallest index.
    always_comb begin
        low_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_r[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start) state_nx = S_SCAN;
            S_SCAN: state_nx = (mask_r == '0) ? S_DONE : S_XFER;
            S_XFER: if (mem_ready) state_nx = S_SCAN;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r     <= '0;
            store_r    <= 1'b0;
            mem_addr   <= '0;
            rf_addr    <= '0;
            xfer_count <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_r     <= reg_mask;
                        store_r    <= is_store;
                        mem_addr   <= base_addr;
                        xfer_count <= '0;
                    end
                end
                S_SCAN: begin
                    if (mask_r != '0) begin
                        rf_addr <= low_idx;
                    end
                end
                S_XFER: begin
                    if (mem_ready) begin
                        mask_r[rf_addr] <= 1'b0;
                        mem_addr        <= mem_addr + ADDR_W'(ADDR_STEP);
                        xfer_count      <= xfer_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode the registered state only; the register write additionally qualifies on mem_ready.
    always_comb begin
        busy       = (state == S_SCAN) || (state == S_XFER);
        done       = (state == S_DONE);
        mem_rd     = (state == S_XFER) && !store_r;
        mem_wr     = (state == S_XFER) && store_r;
        rf_write_n = !((state == S_XFER) && !store_r && mem_ready);
    end

    assign rf_wdata  = mem_rdata;
    assign mem_wdata = rf_rdata;

endmodule
